// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// The auto-repeat feature is enabled with the KEYPAD_REPEAT_EN macro.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {KS_IDLE, KS_PRESS, KS_BLOCK} kscan_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Snapshot bit index is col*4+row; the reported code is {row, col}.
    function automatic key_code_t onehot_code(input logic [15:0] v);
        key_code_t code;
        logic [3:0] bi;
        code = '0;
        for (int b = 0; b < 16; b++) begin
            bi = 4'(b);
            if (v[b]) code = {bi[1:0], bi[3:2]};
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-level debouncer: a candidate snapshot is accepted once it has been
// seen on DEB_SWEEPS consecutive sweeps.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_SWEEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sweep_end,
    input  logic [15:0] cand,
    output logic [15:0] stable,
    output logic        stable_vld
);

    localparam logic [3:0] DEB = 4'(DEB_SWEEPS);

    logic [15:0] prev;
    logic [3:0]  match;
    logic [3:0]  match_nxt;

    always_comb begin
        if (cand == prev) match_nxt = (match >= DEB) ? DEB : match + 4'd1;
        else              match_nxt = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            match      <= '0;
            stable     <= '0;
            stable_vld <= 1'b0;
        end else begin
            stable_vld <= sweep_end;
            if (sweep_end) begin
                prev  <= cand;
                match <= match_nxt;
                if (match_nxt == DEB) stable <= cand;
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce, single-key FSM and valid/ready output.
// Define KEYPAD_REPEAT_EN to build the auto-repeat sweep counter.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELL         = 16,
    parameter int DEB_SWEEPS    = 4,
    parameter int REPEAT_SWEEPS = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output key_code_t key_code,
    output logic      key_valid,
    input  logic      key_ready,
    output logic      key_down,
    output logic      overflow
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       row_sync_p0, row_sync_p1;
    logic [11:0]      snap;
    logic [15:0]      cand_p0;
    logic             vld_p0;
    logic [15:0]      stable_p1;
    logic             vld_p1;
    kscan_state_t     state;
    key_code_t        held;
    key_code_t        code_now;
    logic [4:0]       pop;
    logic             emit;
    logic             rep_hit;

    assign col_n = ~(4'b0001 << col_idx);

    // p0/p1: two-flop synchroniser on the asynchronous row lines
    always_ff @(posedge clk) begin
        row_sync_p0 <= row_n;
        row_sync_p1 <= row_sync_p0;
    end

    // p0: column scan, one nibble per column, full candidate at end of column 3
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            snap      <= '0;
            cand_p0   <= '0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (dwell_cnt == CNT_W'(DWELL - 1)) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                case (col_idx)
                    2'd0:    snap[3:0]  <= ~row_sync_p1;
                    2'd1:    snap[7:4]  <= ~row_sync_p1;
                    2'd2:    snap[11:8] <= ~row_sync_p1;
                    default: begin
                        cand_p0 <= {~row_sync_p1, snap};
                        vld_p0  <= 1'b1;
                    end
                endcase
            end else begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
        end
    end

    // p1: debounced stable snapshot
    keypad_debounce #(.DEB_SWEEPS(DEB_SWEEPS)) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .sweep_end  (vld_p0),
        .cand       (cand_p0),
        .stable     (stable_p1),
        .stable_vld (vld_p1)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SWEEPS + 1);
    logic [REP_W-1:0] rep_cnt;

    assign rep_hit = (rep_cnt == REP_W'(REPEAT_SWEEPS - 1));

    // Counts sweeps since the last emit while the same single key stays held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (vld_p1) begin
            if (emit || pop != 5'd1 || state != KS_PRESS) rep_cnt <= '0;
            else                                          rep_cnt <= rep_cnt + REP_W'(1);
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SWEEPS > 0);
    assign rep_hit       = 1'b0;
`endif

    always_comb begin
        pop      = popcount16(stable_p1);
        code_now = onehot_code(stable_p1);
        emit     = 1'b0;
        if (vld_p1 && pop == 5'd1) begin
            case (state)
                KS_IDLE:  emit = 1'b1;
                KS_PRESS: emit = (code_now != held) || rep_hit;
                default:  emit = 1'b0;
            endcase
        end
    end

    // p2: key FSM and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= KS_IDLE;
            held      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (vld_p1) begin
                if (pop == 5'd1) held <= code_now;
                case (state)
                    KS_IDLE: begin
                        if (pop == 5'd1) begin
                            state    <= KS_PRESS;
                            key_down <= 1'b1;
                        end else if (pop >= 5'd2) begin
                            state <= KS_BLOCK;
                        end
                    end
                    KS_PRESS: begin
                        if (pop == 5'd0) begin
                            state    <= KS_IDLE;
                            key_down <= 1'b0;
                        end else if (pop >= 5'd2) begin
                            state    <= KS_BLOCK;
                            key_down <= 1'b0;
                        end
                    end
                    default: begin
                        if (pop == 5'd0) state <= KS_IDLE;
                    end
                endcase
            end
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= code_now;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (DWELL=4, DEB_SWEEPS=3, REPEAT_SWEEPS=5);
// a keypad model drives row_n from col_n and the pressed-key set.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_down;
    logic        overflow;

    logic [15:0] keys = '0;   // bit index = row*4 + col
    int          n_vec = 0;
    int          n_err = 0;
    int          ev_cnt = 0;
    logic [3:0]  last_code = '0;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_EVENTS = 3;
`else
    localparam int REP_EVENTS = 1;
`endif

    always #5 clk = ~clk;

    keypad_scan #(.DWELL(4), .DEB_SWEEPS(3), .REPEAT_SWEEPS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(posedge clk) begin
        if (!rst && key_valid && key_ready) begin
            ev_cnt    <= ev_cnt + 1;
            last_code <= key_code;
        end
    end

    // Returns on the negedge right after column 0 becomes active.
    task automatic align_sweep();
        logic [3:0] prev;
        prev = col_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && col_n == 4'b1110) return;
            prev = col_n;
        end
        n_vec++; n_err++;
        $display("FAIL align: col_n never wrapped 0111->1110, last %b", col_n);
    endtask

    task automatic test_reset();
        rst = 1'b1; key_ready = 1'b1; keys = '0;
        repeat (4) @(negedge clk);
        n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", col_n); end
        n_vec++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h want 0", key_code); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL reset_down: got %b want 0", key_down); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_scan();
        logic [3:0] exp;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = ~(4'b0001 << (k / 4));
            n_vec++;
            if (col_n !== exp) begin n_err++; $display("FAIL scan_col[%0d]: got %b want %b", k, col_n, exp); end
            @(negedge clk);
        end
        repeat (64) @(negedge clk);
        n_vec++; if (ev_cnt !== 0 || key_valid !== 1'b0) begin
            n_err++; $display("FAIL scan_idle: events %0d valid %b want 0 0", ev_cnt, key_valid);
        end
    endtask

    task automatic test_single();
        int e0;
        e0 = ev_cnt;
        align_sweep();
        keys = 16'h0040;
        repeat (54) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", ev_cnt - e0); end
        n_vec++; if (last_code !== 4'h6) begin n_err++; $display("FAIL single_code: got %h want 6", last_code); end
        n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL single_down: got %b want 1", key_down); end
        keys = '0;
        repeat (96) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL single_after: got %0d want 1", ev_cnt - e0); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL single_up: got %b want 0", key_down); end
    endtask

    task automatic test_bounce();
        int e0;
        e0 = ev_cnt;
        align_sweep();
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            repeat (16) @(negedge clk);
        end
        n_vec++; if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL bounce_quiet: got %0d want 0", ev_cnt - e0); end
        keys = 16'h0001;
        repeat (40) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL bounce_cnt: got %0d want 1", ev_cnt - e0); end
        n_vec++; if (last_code !== 4'h0) begin n_err++; $display("FAIL bounce_code: got %h want 0", last_code); end
        keys = '0;
        repeat (112) @(negedge clk);
    endtask

    task automatic test_overflow();
        int e0;
        e0 = ev_cnt;
        key_ready = 1'b0;
        align_sweep();
        keys = 16'h0020;
        repeat (54) @(negedge clk);
        n_vec++; if (key_valid !== 1'b1 || key_code !== 4'h5) begin
            n_err++; $display("FAIL ovf_first: valid %b code %h want 1 5", key_valid, key_code);
        end
        keys = '0;
        repeat (58) @(negedge clk);
        keys = 16'h0400;
        repeat (58) @(negedge clk);
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", key_valid); end
        n_vec++; if (key_code !== 4'h5) begin n_err++; $display("FAIL ovf_code: got %h want 5", key_code); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_vec++; if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL ovf_noacc: got %0d want 0", ev_cnt - e0); end
        keys = '0;
        key_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drop: got %b want 0", key_valid); end
        n_vec++; if (ev_cnt - e0 !== 1 || last_code !== 4'h5) begin
            n_err++; $display("FAIL ovf_accept: events %0d code %h want 1 5", ev_cnt - e0, last_code);
        end
        repeat (112) @(negedge clk);
    endtask

    task automatic test_block();
        int e0;
        e0 = ev_cnt;
        align_sweep();
        keys = 16'h0006;
        repeat (54) @(negedge clk);
        keys = 16'h0002;
        repeat (64) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL block_quiet: got %0d want 0", ev_cnt - e0); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL block_down: got %b want 0", key_down); end
        keys = '0;
        repeat (112) @(negedge clk);
        align_sweep();
        keys = 16'h0004;
        repeat (54) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL block_cnt: got %0d want 1", ev_cnt - e0); end
        n_vec++; if (last_code !== 4'h2) begin n_err++; $display("FAIL block_code: got %h want 2", last_code); end
        keys = '0;
        repeat (112) @(negedge clk);
    endtask

    task automatic test_repeat_reset();
        int e0;
        e0 = ev_cnt;
        align_sweep();
        keys = 16'h0008;
        repeat (232) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== REP_EVENTS) begin
            n_err++; $display("FAIL repeat_cnt: got %0d want %0d", ev_cnt - e0, REP_EVENTS);
        end
        n_vec++; if (last_code !== 4'h3 || key_down !== 1'b1) begin
            n_err++; $display("FAIL repeat_code: code %h down %b want 3 1", last_code, key_down);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL midrst_col: got %b want 1110", col_n); end
        n_vec++; if (key_code !== 4'h0) begin n_err++; $display("FAIL midrst_code: got %h want 0", key_code); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL midrst_down: got %b want 0", key_down); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
        rst = 1'b0;
        e0 = ev_cnt;
        repeat (56) @(negedge clk);
        n_vec++; if (ev_cnt - e0 !== 1 || last_code !== 4'h3) begin
            n_err++; $display("FAIL rereport: events %0d code %h want 1 3", ev_cnt - e0, last_code);
        end
        keys = '0;
        repeat (112) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single();
        test_bounce();
        test_overflow();
        test_block();
        test_repeat_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
